// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with a one-word TX holding register.
// All SPI pins are resynchronised into the clk domain before use.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic                  sclk_p0, sclk_p1, sclk_p2;
    logic                  cs_p0, cs_p1, cs_p2;
    logic                  mosi_p0, mosi_p1;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                  load_now, shift_now;

    // p0/p1 synchronise, p2 is the previous sample for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;

    // A deselect in the same cycle as an sclk edge wins over that edge.
    always_comb begin
        load_now  = 1'b0;
        shift_now = 1'b0;
        if (state == IDLE) begin
            load_now = cs_fall;
        end else if (!cs_rise && sclk_fall) begin
            load_now  = (bit_cnt == '0) && word_done;
            shift_now = !load_now;
        end
    end

    assign miso = tx_shift[DATA_WIDTH-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_data   <= '0;
            tx_ready    <= 1'b1;
            tx_shift    <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load_now) begin
                if (!tx_ready) begin
                    tx_shift <= hold_data;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_now) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            // Accept only happens when empty, so it never collides with a real load.
            if (tx_valid && tx_ready) begin
                hold_data <= tx_data;
                tx_ready  <= 1'b0;
            end else if (load_now && !tx_ready) begin
                tx_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso_oe   <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        busy      <= 1'b1;
                        miso_oe   <= 1'b1;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        miso_oe   <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_p1};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                            rx_data   <= {rx_shift, mosi_p1};
                            rx_valid  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (load_now) begin
                        word_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus a randomized run, checked by
// a scoreboard of expected RX words and a queue model of the TX word stream.
module tb_spi_slave;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [W-1:0] rx_data;

    int checks = 0;
    int errors = 0;
    int urun_seen = 0;
    int urun_exp = 0;
    int rxv_seen = 0;
    bit prod_run = 1'b0;

    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];

    spi_slave #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest word the master sent.
    initial begin
        logic [W-1:0] exp_rx;
        forever begin
            @(negedge clk);
            if (rstn && rx_valid) begin
                rxv_seen++;
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
                end else begin
                    exp_rx = rxq.pop_front();
                    check("rx_word", 32'(rx_data), 32'(exp_rx));
                end
            end
            if (rstn && tx_underrun) urun_seen++;
        end
    end

    task automatic load_tx(input logic [W-1:0] d);
        int n = 0;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL load_tx_timeout: tx_ready %0b expected 1", tx_ready);
            return;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        txq.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // One word as a mode-0 master; nedges < 2*W leaves the word unfinished.
    task automatic spi_word(input logic [W-1:0] mo, input int half, input bit last,
                            input int nedges);
        logic [W-1:0] mi;
        logic [W-1:0] exp_tx;
        mi = '0;
        if (txq.size() > 0) begin
            exp_tx = txq.pop_front();
        end else begin
            exp_tx = '0;
            urun_exp++;
        end
        if (nedges == 2 * W) rxq.push_back(mo);
        for (int e = 0; e < nedges; e++) begin
            if (e % 2 == 0) begin
                mosi = mo[W-1-e/2];
                repeat (half) @(negedge clk);
                sclk = 1'b1;
                mi[W-1-e/2] = miso;
            end else begin
                repeat (half) @(negedge clk);
                sclk = 1'b0;
                if (e == 2 * W - 1 && last) cs_n = 1'b1;
            end
        end
        if (nedges == 2 * W) check("miso_word", 32'(mi), 32'(exp_tx));
    endtask

    task automatic wait_full();
        int t = 0;
        while (tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready) begin
            checks++;
            errors++;
            $display("FAIL hold_fill_timeout: tx_ready %0b expected 0", tx_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'h0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'h0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'h1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int base_rx, base_ur, words, n, half;
        logic [W-1:0] d;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Single word
        base_rx = rxv_seen;
        base_ur = urun_seen;
        load_tx(8'hA5);
        check("t1_hold_full", 32'(tx_ready), 32'h0);
        cs_n = 1'b0;
        fork
            spi_word(8'h3C, 4, 1'b1, 16);
            begin
                repeat (4) @(negedge clk);
                check("t1_tx_ready_after_cs", 32'(tx_ready), 32'h1);
                check("t1_busy", 32'(busy), 32'h1);
                check("t1_miso_oe", 32'(miso_oe), 32'h1);
            end
        join
        repeat (10) @(negedge clk);
        check("t1_rx_pulses", 32'(rxv_seen - base_rx), 32'd1);
        check("t1_underruns", 32'(urun_seen - base_ur), 32'd0);

        // Back-to-back words under one select
        base_rx = rxv_seen;
        base_ur = urun_seen;
        load_tx(8'h12);
        cs_n = 1'b0;
        fork
            spi_word(8'hF0, 4, 1'b0, 16);
            begin
                repeat (10) @(negedge clk);
                load_tx(8'h34);
            end
        join
        spi_word(8'h0F, 4, 1'b1, 16);
        repeat (10) @(negedge clk);
        check("t2_rx_pulses", 32'(rxv_seen - base_rx), 32'd2);
        check("t2_underruns", 32'(urun_seen - base_ur), 32'd0);

        // Underrun: nothing in the holding register
        base_rx = rxv_seen;
        base_ur = urun_seen;
        cs_n = 1'b0;
        spi_word(8'h6B, 4, 1'b1, 16);
        repeat (10) @(negedge clk);
        check("t3_underruns", 32'(urun_seen - base_ur), 32'd1);
        check("t3_rx_pulses", 32'(rxv_seen - base_rx), 32'd1);

        // Abort after 5 sclk edges; a trailing sclk fall lands in IDLE
        base_rx = rxv_seen;
        load_tx(8'h5A);
        cs_n = 1'b0;
        spi_word(8'hFF, 4, 1'b0, 5);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_miso_oe", 32'(miso_oe), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_rx_pulses", 32'(rxv_seen - base_rx), 32'd0);
        check("t4_hold_empty", 32'(tx_ready), 32'h1);
        load_tx(8'hC3);
        cs_n = 1'b0;
        spi_word(8'h96, 4, 1'b1, 16);
        repeat (10) @(negedge clk);
        check("t4_next_rx_pulses", 32'(rxv_seen - base_rx), 32'd1);

        // Reset pulsed mid-word
        base_rx = rxv_seen;
        load_tx(8'h77);
        cs_n = 1'b0;
        spi_word(8'h55, 4, 1'b0, 6);
        rstn = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        txq.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_rx_pulses", 32'(rxv_seen - base_rx), 32'd0);
        load_tx(8'h3E);
        cs_n = 1'b0;
        spi_word(8'h81, 4, 1'b1, 16);
        repeat (10) @(negedge clk);
        check("t5_next_rx_pulses", 32'(rxv_seen - base_rx), 32'd1);
        check("t5_rx_data", 32'(rx_data), 32'h81);

        // Randomized frames of 1..4 words, sclk = clk/8 .. clk/32
        prod_run = 1'b1;
        fork
            begin
                while (prod_run) begin
                    @(negedge clk);
                    if (tx_ready && !tx_valid) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        d = W'($urandom);
                        tx_data  = d;
                        tx_valid = 1'b1;
                        txq.push_back(d);
                        @(negedge clk);
                        tx_valid = 1'b0;
                    end
                end
            end
            begin
                words = 0;
                while (words < 200) begin
                    n = int'($urandom_range(1, 4));
                    if (n > 200 - words) n = 200 - words;
                    half = int'($urandom_range(4, 16));
                    wait_full();
                    cs_n = 1'b0;
                    for (int k = 0; k < n; k++) begin
                        spi_word(W'($urandom), half, (k == n - 1), 16);
                    end
                    words += n;
                    repeat ($urandom_range(2, 20)) @(negedge clk);
                end
                prod_run = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        txq.delete();

        check("rx_queue_drained", 32'(rxq.size()), 32'd0);
        check("underrun_total", 32'(urun_seen), 32'(urun_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
